// File: rtl/pipe_resp_checker_pkg.sv
// Shared definitions for the pipeline response checker.
// Holds the FSM state encoding and a saturating-increment helper.
// Imported by pipe_resp_checker; no ports.
package pipe_resp_checker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_delay_line.sv
// Enabled shift register, DEPTH stages of WIDTH bits; q is d delayed by DEPTH enabled edges.
// Latency: DEPTH enabled cycles. No backpressure; holds contents while en=0.
// Ports: clk, rst (async active-high), en (shift enable), d (input word), q (oldest stage).
module pipe_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pipe_resp_checker.sv
// Checks a LATENCY-deep registered AND pipeline against a delayed golden model.
// Latency: result on check_valid/mismatch 1 cycle after the compared edge.
// Ports: clk, rst, en, clr, dut_in, dut_out in; check_valid, mismatch, err_sticky,
//        err_count, chk_count, first_exp, first_act out. Passive; never stalls the pipeline.
module pipe_resp_checker
    import pipe_resp_checker_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             check_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act
);

    localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);

    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic              dly_q;
    logic [WIDTH-1:0]  exp_word;
    logic              compare_now;
    logic              miss_now;

    // Only the AND-reduction matters, so the delay line is one bit wide.
    pipe_delay_line #(
        .WIDTH (1),
        .DEPTH (LATENCY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (&dut_in),
        .q   (dly_q)
    );

    // FILL spends LATENCY edges so the delay line holds only fresh samples
    // before the first compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
        end else if (!en) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FILL;
                    fill_cnt <= '0;
                end
                ST_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_CHECK: state <= ST_CHECK;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign exp_word    = {WIDTH{dly_q}};
    assign compare_now = en && (state == ST_CHECK);

    // Simulation treats X/Z on dut_out as a failure; synthesis has no X.
`ifdef SYNTHESIS
    assign miss_now = (dut_out != exp_word);
`else
    assign miss_now = (dut_out !== exp_word);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_valid <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            check_valid <= compare_now;
            mismatch    <= compare_now && miss_now;
        end
    end

    // clr outranks a same-edge compare: that compare is reported but not recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (compare_now) begin
            chk_count <= CNT_W'(sat_inc(32'(chk_count), CNT_W));
            if (miss_now) begin
                err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                if (!err_sticky) begin
                    err_sticky <= 1'b1;
                    first_exp  <= exp_word;
                    first_act  <= dut_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_resp_checker.sv
module tb_pipe_resp_checker;

    localparam int W   = 3;
    localparam int LAT = 3;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic [W-1:0]  dut_in;
    logic [W-1:0]  dut_out;
    logic          check_valid;
    logic          mismatch;
    logic          err_sticky;
    logic [CW-1:0] err_count;
    logic [CW-1:0] chk_count;
    logic [W-1:0]  first_exp;
    logic [W-1:0]  first_act;

    pipe_resp_checker #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .check_valid (check_valid),
        .mismatch    (mismatch),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .chk_count   (chk_count),
        .first_exp   (first_exp),
        .first_act   (first_act)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: history of every sampled input word and the
    // number of consecutive edges with en=1 since reset.
    logic [W-1:0] hist [$];
    int           m_run;
    logic         m_cv, m_mm, m_stk;
    int           m_ec, m_cc;
    logic [W-1:0] m_fe, m_fa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("check_valid", 32'(check_valid), 32'(m_cv));
        chk("mismatch",    32'(mismatch),    32'(m_mm));
        chk("err_sticky",  32'(err_sticky),  32'(m_stk));
        chk("err_count",   32'(err_count),   32'(m_ec));
        chk("chk_count",   32'(chk_count),   32'(m_cc));
        chk("first_exp",   32'(first_exp),   32'(m_fe));
        chk("first_act",   32'(first_act),   32'(m_fa));
    endtask

    task automatic model_reset();
        m_run = 0; m_cv = 0; m_mm = 0; m_stk = 0;
        m_ec = 0; m_cc = 0; m_fe = '0; m_fa = '0;
    endtask

    // One clock: drive inputs, take the edge, update model, check at edge+1.
    // corrupt: 0 = correct pipeline output, 1 = flip bit 1, 2 = invert, 3 = flip bit 0.
    task automatic step(input logic e, input logic [W-1:0] din, input int corrupt, input logic c);
        logic [W-1:0] exp_w;
        logic [W-1:0] dout;
        logic         cmp;
        logic         miss;
        exp_w = (hist.size() >= LAT) ? {W{&hist[hist.size()-LAT]}} : '0;
        case (corrupt)
            1: dout = exp_w ^ 3'b010;
            2: dout = ~exp_w;
            3: dout = exp_w ^ 3'b001;
            default: dout = exp_w;
        endcase
        en = e; dut_in = din; dut_out = dout; clr = c;
        @(posedge clk);
        #1;
        hist.push_back(din);
        m_run = e ? m_run + 1 : 0;
        // A compare needs en held through FILL entry, LATENCY fill edges and the compare edge.
        cmp  = (m_run >= LAT + 2);
        miss = (dout !== exp_w);
        m_cv = cmp;
        m_mm = cmp && miss;
        if (c) begin
            m_ec = 0; m_cc = 0; m_stk = 0; m_fe = '0; m_fa = '0;
        end else if (cmp) begin
            if (m_cc < CMAX) m_cc++;
            if (miss) begin
                if (m_ec < CMAX) m_ec++;
                if (!m_stk) begin
                    m_stk = 1; m_fe = exp_w; m_fa = dout;
                end
            end
        end
        check_all();
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        rst = 1'b1; en = 1'b0; clr = 1'b0; dut_in = '0; dut_out = '0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;
        step(1'b0, 3'b000, 0, 1'b0);

        // Hold 111 with a correct pipeline; measure edges until first check_valid.
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            step(1'b1, 3'b111, 0, 1'b0);
            n++;
            seen = check_valid;
        end
        chk("first_cv_latency", 32'(n), 32'(LAT + 2));
        for (int i = 0; i < 9; i++) step(1'b1, 3'b111, 0, 1'b0);
        chk("ten_compares", 32'(chk_count), 32'd10);
        chk("no_errors", 32'(err_count), 32'd0);

        // Alternate 111 / 011 against a correct pipeline.
        for (int i = 0; i < 12; i++) step(1'b1, (i % 2 == 0) ? 3'b111 : 3'b011, 0, 1'b0);

        // Two injected errors three cycles apart while 111 is expected.
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 0, 1'b0);
        step(1'b1, 3'b111, 1, 1'b0);
        step(1'b1, 3'b111, 0, 1'b0);
        step(1'b1, 3'b111, 0, 1'b0);
        step(1'b1, 3'b111, 3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 0, 1'b0);
        chk("inj_err_count", 32'(err_count), 32'd2);
        chk("inj_first_exp", 32'(first_exp), 32'(3'b111));
        chk("inj_first_act", 32'(first_act), 32'(3'b101));
        chk("inj_sticky",    32'(err_sticky), 32'd1);

        // Drop en for two cycles; count the silent cycles before compares resume.
        step(1'b0, 3'b111, 0, 1'b0);
        step(1'b0, 3'b111, 0, 1'b0);
        n = 2; seen = 0;
        while (!seen && n < 20) begin
            step(1'b1, 3'b111, 0, 1'b0);
            seen = check_valid;
            if (!seen) n++;
        end
        chk("en_gap_cycles", 32'(n), 32'(2 + LAT + 1));

        // 300 consecutive mismatches saturate the error counter.
        for (int i = 0; i < 300; i++) step(1'b1, 3'($urandom_range(0, 7)), 2, 1'b0);
        chk("err_saturated", 32'(err_count), 32'(CMAX));
        step(1'b1, 3'b111, 2, 1'b1);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_sticky",    32'(err_sticky), 32'd0);
        chk("clr_mismatch",  32'(mismatch), 32'd1);

        // Randomized traffic with occasional errors, en drops and clears.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) != 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset between edges, mid-CHECK.
        for (int i = 0; i < 8; i++) step(1'b1, 3'b111, 0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            step(1'b1, 3'b111, 0, 1'b0);
            n++;
            seen = check_valid;
        end
        chk("post_reset_latency", 32'(n), 32'(LAT + 2));
        for (int i = 0; i < 5; i++) step(1'b1, 3'($urandom_range(0, 7)), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
